// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL bit positions and byte-lane helpers for the multi-channel timer.
package multi_timer_pkg;

  localparam int MaxChannels = 16;

  localparam logic [9:0] OFF_MTIME_LO = 10'h000;
  localparam logic [9:0] OFF_MTIME_HI = 10'h004;
  localparam logic [9:0] OFF_PRESCALE = 10'h008;
  localparam logic [9:0] OFF_STATUS   = 10'h00C;
  localparam logic [9:0] OFF_INTR_EN  = 10'h010;

  localparam logic [9:0] CHAN_BASE   = 10'h100;
  localparam int         CHAN_STRIDE = 16;

  // Word index within a channel block (offset[3:2])
  localparam logic [1:0] CH_CMP_LO = 2'd0;
  localparam logic [1:0] CH_CMP_HI = 2'd1;
  localparam logic [1:0] CH_CTRL   = 2'd2;
  localparam logic [1:0] CH_PERIOD = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;

  typedef struct packed {
    logic cmp_lo;
    logic cmp_hi;
    logic ctrl;
    logic period;
  } chan_wr_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] m;
    m = be_mask(be);
    return (old & ~m) | (wd & m);
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One compare channel: CMP/CTRL/PERIOD registers, 64-bit compare, auto-reload and sticky status.
module multi_timer_channel
  import multi_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] mtime,
  input  chan_wr_t    wr,
  input  logic [31:0] wval,
  input  logic        status_clr,
  output logic [63:0] cmp,
  output logic [1:0]  ctrl,
  output logic [31:0] period,
  output logic        status
);

  logic        fire;
  logic [63:0] cmp_d;
  logic [1:0]  ctrl_d;

  assign fire = ctrl[CTRL_EN] && (mtime >= cmp);

  // A software write to a field in the fire cycle takes precedence over reload / en-clear
  always_comb begin
    cmp_d  = cmp;
    ctrl_d = ctrl;
    if (wr.cmp_lo) cmp_d[31:0] = wval;
    if (wr.cmp_hi) cmp_d[63:32] = wval;
    if (fire && ctrl[CTRL_PERIODIC] && !(wr.cmp_lo || wr.cmp_hi))
      cmp_d = cmp + {32'd0, period};
    if (wr.ctrl)
      ctrl_d = wval[1:0];
    else if (fire && !ctrl[CTRL_PERIODIC])
      ctrl_d[CTRL_EN] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmp    <= '0;
      ctrl   <= '0;
      period <= '0;
      status <= 1'b0;
    end else begin
      cmp    <= cmp_d;
      ctrl   <= ctrl_d;
      if (wr.period) period <= wval;
      status <= fire | (status & ~status_clr);
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Bus-attached timer: prescaled 64-bit mtime, register decode, response path and channel array.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int NumChannels   = 4,
  parameter int PrescaleWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    timer_req_i,
  input  logic                    timer_we_i,
  input  logic [3:0]              timer_be_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,
  output logic                    timer_intr_o,
  output logic [NumChannels-1:0]  chan_intr_o
);

  logic [9:0]  off;
  logic [3:0]  ch_idx;
  logic [1:0]  word;
  logic        glb_hit, ch_hit, hit, wr_en, tick;
  logic [31:0] rd_val, wval, clr_word;

  logic [63:0]              mtime;
  logic [PrescaleWidth-1:0] prescale, pre_cnt;
  logic [NumChannels-1:0]   intr_en, status_q, stat_clr;

  logic [NumChannels-1:0][63:0] cmp_q;
  logic [NumChannels-1:0][1:0]  ctrl_q;
  logic [NumChannels-1:0][31:0] period_q;

  logic unused_addr;
  assign unused_addr = ^timer_addr_i[AddressWidth-1:10];

  assign off    = timer_addr_i[9:0];
  assign ch_idx = off[7:4];
  assign word   = off[3:2];

  always_comb begin
    glb_hit = off inside {OFF_MTIME_LO, OFF_MTIME_HI, OFF_PRESCALE, OFF_STATUS, OFF_INTR_EN};
    ch_hit  = 1'b0;
    for (int n = 0; n < NumChannels; n++)
      if (off[9:8] == CHAN_BASE[9:8] && ch_idx == 4'(n)) ch_hit = 1'b1;
    hit = (off[1:0] == 2'b00) && (glb_hit || ch_hit);
  end

  always_comb begin
    rd_val = '0;
    if (glb_hit) begin
      case (off)
        OFF_MTIME_LO: rd_val = mtime[31:0];
        OFF_MTIME_HI: rd_val = mtime[63:32];
        OFF_PRESCALE: rd_val = 32'(prescale);
        OFF_STATUS:   rd_val = 32'(status_q);
        OFF_INTR_EN:  rd_val = 32'(intr_en);
        default:      rd_val = '0;
      endcase
    end else begin
      for (int n = 0; n < NumChannels; n++) begin
        if (ch_hit && ch_idx == 4'(n)) begin
          case (word)
            CH_CMP_LO: rd_val = cmp_q[n][31:0];
            CH_CMP_HI: rd_val = cmp_q[n][63:32];
            CH_CTRL:   rd_val = 32'(ctrl_q[n]);
            default:   rd_val = period_q[n];
          endcase
        end
      end
    end
  end

  // Byte-lane merge against the addressed register's current value
  assign wval     = be_merge(rd_val, timer_wdata_i, timer_be_i);
  assign wr_en    = timer_req_i && timer_we_i && hit;
  assign tick     = (pre_cnt == prescale);
  assign clr_word = timer_wdata_i & be_mask(timer_be_i);
  assign stat_clr = (wr_en && off == OFF_STATUS) ? clr_word[NumChannels-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime          <= '0;
      prescale       <= '0;
      pre_cnt        <= '0;
      intr_en        <= '0;
      timer_rvalid_o <= 1'b0;
      timer_err_o    <= 1'b0;
      timer_rdata_o  <= '0;
    end else begin
      timer_rvalid_o <= timer_req_i;
      timer_err_o    <= timer_req_i && !hit;
      timer_rdata_o  <= (timer_req_i && hit && !timer_we_i) ? rd_val : '0;

      if (wr_en && off == OFF_PRESCALE) begin
        prescale <= wval[PrescaleWidth-1:0];
        pre_cnt  <= '0;
      end else begin
        pre_cnt  <= tick ? '0 : pre_cnt + PrescaleWidth'(1);
      end

      if (wr_en && off == OFF_MTIME_LO)      mtime[31:0]  <= wval;
      else if (wr_en && off == OFF_MTIME_HI) mtime[63:32] <= wval;
      else if (tick)                         mtime        <= mtime + 64'd1;

      if (wr_en && off == OFF_INTR_EN) intr_en <= wval[NumChannels-1:0];
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    logic     sel;
    chan_wr_t wr;
    assign sel = wr_en && ch_hit && (ch_idx == 4'(g));
    assign wr  = '{cmp_lo: sel && word == CH_CMP_LO && (|timer_be_i),
                   cmp_hi: sel && word == CH_CMP_HI && (|timer_be_i),
                   ctrl:   sel && word == CH_CTRL && timer_be_i[0],
                   period: sel && word == CH_PERIOD};

    multi_timer_channel u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .mtime      (mtime),
      .wr         (wr),
      .wval       (wval),
      .status_clr (stat_clr[g]),
      .cmp        (cmp_q[g]),
      .ctrl       (ctrl_q[g]),
      .period     (period_q[g]),
      .status     (status_q[g])
    );
  end

  assign chan_intr_o  = status_q & intr_en;
  assign timer_intr_o = |chan_intr_o;

endmodule

// File: tb/tb_multi_timer.sv
// Directed scenarios plus randomized bus traffic, every cycle compared against a register-level model.
module tb_multi_timer;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0, we = 1'b0;
  logic [3:0]     be = 4'h0;
  logic [31:0]    addr = '0, wdata = '0;
  logic           rvalid, err, tintr;
  logic [31:0]    rdata;
  logic [NCH-1:0] cintr;

  int n_chk = 0, n_fail = 0;

  // Reference model state
  logic [63:0]    m_mtime;
  logic [15:0]    m_pre, m_prescale;
  logic [63:0]    m_cmp[NCH];
  logic [1:0]     m_ctrl[NCH];
  logic [31:0]    m_period[NCH];
  logic [NCH-1:0] m_status, m_ien;
  logic           m_rvalid, m_err;
  logic [31:0]    m_rdata;
  logic [31:0]    last_rdata;
  logic           last_err;

  always #5 clk = ~clk;

  multi_timer #(.NumChannels(NCH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .timer_req_i   (req),
    .timer_we_i    (we),
    .timer_be_i    (be),
    .timer_addr_i  (addr),
    .timer_wdata_i (wdata),
    .timer_rvalid_o(rvalid),
    .timer_rdata_o (rdata),
    .timer_err_o   (err),
    .timer_intr_o  (tintr),
    .chan_intr_o   (cintr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the register map as described at the bus level
  task automatic model_step();
    logic [9:0]     off;
    logic [31:0]    rv, bm, wv;
    logic [NCH-1:0] fire, clr;
    logic           tick, valid, wr;
    int             o, n, r;
    if (!rst_n) begin
      m_mtime = '0; m_pre = '0; m_prescale = '0; m_status = '0; m_ien = '0;
      m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
      for (int i = 0; i < NCH; i++) begin
        m_cmp[i] = '0; m_ctrl[i] = '0; m_period[i] = '0;
      end
      return;
    end
    off = addr[9:0]; o = int'(off); valid = 1'b0; rv = '0; n = -1; r = 0;
    if (off[1:0] == 2'b00) begin
      if (o < 256) begin
        valid = 1'b1;
        case (o)
          0:  rv = m_mtime[31:0];
          4:  rv = m_mtime[63:32];
          8:  rv = {16'd0, m_prescale};
          12: rv = {28'd0, m_status};
          16: rv = {28'd0, m_ien};
          default: valid = 1'b0;
        endcase
      end else if (o < 512) begin
        n = (o - 256) / 16; r = o % 16;
        if (n < NCH) begin
          valid = 1'b1;
          case (r)
            0: rv = m_cmp[n][31:0];
            4: rv = m_cmp[n][63:32];
            8: rv = {30'd0, m_ctrl[n]};
            default: rv = m_period[n];
          endcase
        end
      end
    end
    m_rvalid = req;
    m_err    = req && !valid;
    m_rdata  = (req && valid && !we) ? rv : '0;
    bm   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wv   = (rv & ~bm) | (wdata & bm);
    wr   = req && we && valid;
    tick = (m_pre == m_prescale);
    for (int i = 0; i < NCH; i++) fire[i] = m_ctrl[i][0] && (m_mtime >= m_cmp[i]);

    clr = (wr && o == 12) ? wdata[NCH-1:0] & bm[NCH-1:0] : '0;
    m_status = (m_status & ~clr) | fire;
    if (wr && o == 16) m_ien = wv[NCH-1:0];
    if (wr && o == 8) begin m_prescale = wv[15:0]; m_pre = '0; end
    else m_pre = tick ? 16'd0 : m_pre + 16'd1;
    if (wr && o == 0)      m_mtime[31:0]  = wv;
    else if (wr && o == 4) m_mtime[63:32] = wv;
    else if (tick)         m_mtime        = m_mtime + 64'd1;

    for (int i = 0; i < NCH; i++) begin
      logic cw;
      cw = wr && o >= 256 && n == i;
      if (cw && (r == 0 || r == 4) && be != 4'h0) begin
        if (r == 0) m_cmp[i][31:0] = wv; else m_cmp[i][63:32] = wv;
      end else if (fire[i] && m_ctrl[i][1]) m_cmp[i] = m_cmp[i] + {32'd0, m_period[i]};
      if (cw && r == 8 && be[0]) m_ctrl[i] = wv[1:0];
      else if (fire[i] && !m_ctrl[i][1]) m_ctrl[i][0] = 1'b0;
      if (cw && r == 12) m_period[i] = wv;
    end
  endtask

  task automatic step(input logic q, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
    req = q; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    model_step();
    #1;
    chk("rvalid", rvalid, m_rvalid);
    if (m_rvalid) begin
      chk("err", err, m_err);
      chk("rdata", rdata, m_rdata);
    end
    chk("chan_intr", cintr, m_status & m_ien);
    chk("timer_intr", tintr, |(m_status & m_ien));
    last_rdata = rdata;
    last_err   = err;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b = 4'hF);
    step(1'b1, 1'b1, b, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, 4'hF, a, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  initial begin
    int lat;
    int exp_m[3];
    exp_m = '{5, 13, 21};

    // Reset and first reads
    idle(); idle();
    rst_n = 1'b1;
    rd(32'h000); chk("rst_mtime_lo", last_rdata, 0); chk("rst_err", last_err, 0);
    rd(32'h004); chk("rst_mtime_hi", last_rdata, 0);
    rd(32'h00C); chk("rst_status", last_rdata, 0);

    // One-shot: first tick one cycle after enable, then 4 cycles per tick, one cycle to status
    wr(32'h100, 10); wr(32'h104, 0); wr(32'h010, 1); wr(32'h008, 3);
    wr(32'h004, 0); wr(32'h000, 0); wr(32'h108, 1);
    lat = 0;
    while (!cintr[0] && lat < 60) begin idle(); lat++; end
    chk("oneshot_latency", lat, 1 + 4 * 9 + 1);
    rd(32'h108); chk("oneshot_ctrl", last_rdata, 0);
    wr(32'h00C, 1); chk("oneshot_clr", cintr[0], 0);

    // Periodic reload at 5, 13, 21
    wr(32'h008, 0); wr(32'h110, 5); wr(32'h114, 0); wr(32'h11C, 8); wr(32'h010, 3);
    wr(32'h004, 0); wr(32'h000, 0); wr(32'h118, 3);
    foreach (exp_m[k]) begin
      lat = 0;
      while (!cintr[1] && lat < 40) begin idle(); lat++; end
      chk("periodic_seen", lat < 40, 1);
      rd(32'h000); chk("periodic_mtime", last_rdata, exp_m[k] + 1);
      wr(32'h00C, 2); chk("periodic_clr", cintr[1], 0);
    end

    // Wrap to zero, then freeze mtime with a large prescale
    wr(32'h118, 0); wr(32'h008, 0); wr(32'h004, 32'hFFFF_FFFF); wr(32'h000, 32'hFFFF_FFFE);
    idle(); wr(32'h008, 32'hFFFF);
    rd(32'h004); chk("wrap_hi", last_rdata, 0);
    rd(32'h000); chk("wrap_lo", last_rdata, 0);

    // Address errors
    rd(32'h140); chk("err_chan4", last_err, 1); chk("err_chan4_rdata", last_rdata, 0);
    rd(32'h3FC); chk("err_3fc", last_err, 1); chk("err_3fc_rdata", last_rdata, 0);
    wr(32'h002, 32'hFFFF_FFFF); chk("err_misaligned", last_err, 1);
    rd(32'h000); chk("err_no_change", last_rdata, 0);

    // W1C in the same cycle as a fire: set wins
    wr(32'h100, 0); wr(32'h104, 0); wr(32'h010, 1); wr(32'h00C, 32'hF); wr(32'h108, 1);
    wr(32'h00C, 1); chk("collision_set", cintr[0], 1);
    wr(32'h00C, 1); chk("collision_clr", cintr[0], 0);

    // Partial byte enables
    wr(32'h120, 32'h1122_3344); wr(32'h120, 32'hAABB_CCDD, 4'b0001);
    rd(32'h120); chk("be_lane0", last_rdata, 32'h1122_33DD);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a, d;
      logic [9:0]  a10;
      int          sel;
      rst_n = ($urandom_range(0, 399) != 0);
      sel = $urandom_range(0, 15);
      if (sel < 5)       a = 32'(sel * 4);
      else if (sel < 14) a = 32'(256 + $urandom_range(0, NCH) * 16 + $urandom_range(0, 3) * 4);
      else               a = {$urandom} & 32'h3FF;
      a10 = a[9:0];
      if (a10 == 0 || (a10 >= 256 && a10[3:0] == 0))      d = m_mtime[31:0] + $urandom_range(0, 40);
      else if (a10 == 4 || (a10 >= 256 && a10[3:0] == 4)) d = m_mtime[63:32];
      else if (a10 == 12 || a10 == 16 || (a10 >= 256 && a10[3:0] == 8)) d = $urandom;
      else                                                 d = $urandom_range(0, 3);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF, a, d);
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
